control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
Multicycle main control unit for the 64-bit RISC-V datapath. It sits directly upstream of the datapath top and drives every control flag that the datapath consumes. It sequences FETCH/DECODE/EXECUTE/MEM/WB using the IR opcode and funct3, plus ready handshakes from the instruction and data memories. Supported instructions are R-type ALU (0110011), I-type ALU (0010011), LD (0000011), SD (0100011), BEQ and BNE (1100011); any other encoding halts the unit.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock; single clock domain
reset  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
imem_ready  in  1  instruction memory has valid data this cycle
dmem_ready  in  1  data memory read data valid / write accepted this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by ALU zero
BranchInv  out  1  1: qualify PCWriteCond with !zero (BNE)
PCSource  out  2  00 alu_res, 01 ALUOut register, 10/11 reserved (never driven)
ALUSrcA  out  1  0 PC, 1 regA
ALUSrcB  out  2  00 regB, 01 const 4, 10 imm, 11 reserved
ALUOp  out  2  00 add, 01 sub, 10 R-type funct decode, 11 I-type funct decode
LoadAOut, LoadRegA, LoadRegB, LoadMDR  out  1 each  register loads
RegWrite, MemToReg  out  1 each  regfile write, writeback select (1 = MDR)
IMemRead, IRWrite  out  1 each  instruction fetch, IR load
DMemRead, DMemWrite  out  1 each  data memory strobes
halted  out  1  in HALT state
retire  out  1  one-cycle pulse on the last cycle of each instruction
instret  out  CNT_W  retired-instruction count

Behaviour:
- Output style: Moore outputs, combinational from the state register, except that handshake-gated loads also depend on the ready inputs. Unlisted outputs in a state are 0. The state register is the only FSM storage; instret is a separate counter.
- Reset: on a clk edge with reset=1, state <= FETCH and instret <= 0. While reset=1, all write/load/strobe outputs and retire are forced to 0; the select outputs show their FETCH values. Reset asserted mid-instruction abandons that instruction without any write.
- FETCH: IMemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite are asserted only when imem_ready=1, and the state then moves to DECODE. Otherwise the unit stays in FETCH with no writes (wait states are unbounded).
- DECODE: LoadRegA=1, LoadRegB=1, ALUSrcA=0, ALUSrcB=10, ALUOp=00, LoadAOut=1. This precomputes the branch target (imm is a byte offset). Next state by opcode: LD/SD go to MEM_ADDR, R goes to EXEC_R, I goes to EXEC_I, branch goes to BRANCH, anything else goes to HALT.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, LoadAOut=1. Next is MEM_READ if opcode=LD, else MEM_WRITE.
- MEM_READ: DMemRead=1 and LoadMDR=dmem_ready. When dmem_ready=1, go to MEM_WB; otherwise hold.
- MEM_WB: RegWrite=1, MemToReg=1, retire=1, then FETCH.
- MEM_WRITE: DMemWrite=1 held until dmem_ready=1. On that cycle retire=1 and the next state is FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10, LoadAOut=1, then ALU_WB.
- EXEC_I: as EXEC_R but with ALUSrcB=10 and ALUOp=11, then ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0, retire=1, then FETCH.
- BRANCH: valid only for funct3 000 (BEQ) and 001 (BNE).
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchInv=funct3[0], retire=1.
  - Next state is FETCH.
  - Any other funct3 asserts no writes and goes to HALT.
- HALT: halted=1 and all writes are 0. The unit stays in HALT until reset.
- Latency in cycles with zero wait states: R/I 4, LD 5, SD 4, BEQ/BNE 3. Each wait cycle adds exactly 1.
- Ready inputs are ignored in states that do not sample them.
- instret increments by 1 on every cycle with retire=1 and wraps modulo 2^CNT_W.

Decomposition:
- Package control_pkg holds:
  - state_t enum: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, HALT.
  - Opcode constants: OP_R, OP_I, OP_LD, OP_SD, OP_BR.
  - Encoding localparams for ALUSrcB, ALUOp and PCSource.
- No sub-module: a single module containing the state register, next-state logic, output decode and the instret counter.

Test Plan:
- Zero-wait add (opcode 0110011), ready inputs tied high → state sequence FETCH, DECODE, EXEC_R, ALU_WB, FETCH. RegWrite=1 only in cycle 4. instret goes 0→1.
- LD with dmem_ready low for 3 cycles → DMemRead held for 4 cycles and LoadMDR pulses once. MEM_WB occurs at cycle 8 after the start of FETCH. retire pulses once.
- BNE (funct3 001) then BEQ (funct3 000) → PCWriteCond=1 and PCSource=01 in the third cycle. BranchInv is 1 then 0. Each instruction takes 3 cycles.
- SD with imem_ready low for 2 FETCH cycles → no IRWrite or PCWrite during the wait. DMemWrite=1 for exactly 1 cycle. Total 6 cycles.
- Opcode 1111111, and separately branch funct3 100 → HALT with halted=1 and no writes for 10 cycles. A reset pulse returns the unit to FETCH with instret=0.
- Reset asserted during MEM_READ → next state is FETCH. DMemRead, LoadMDR and RegWrite are never asserted for the aborted LD, and instret is unchanged.

Source files
------------

// File: rtl/control_pkg.sv
// control_pkg: shared types and encodings for the multicycle RISC-V control FSM.
//   state_t       : FSM state enumeration
//   OP_*          : supported major opcodes (IR[6:0])
//   F3_*          : branch funct3 codes
//   SRCB_*/ALUOP_*/PCSRC_* : datapath select encodings
package control_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        BRANCH,
        HALT
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_AOUT = 2'b01;

endpackage

// File: rtl/control_fsm.sv
// control_fsm: multicycle main control unit for the 64-bit RISC-V datapath.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB from the IR opcode/funct3 and the
// instruction/data memory ready handshakes.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   opcode, funct3             : IR[6:0], IR[14:12]
//   imem_ready, dmem_ready     : memory handshakes
//   PCWrite..DMemWrite         : datapath control flags (Moore, ready-gated loads)
//   halted                     : unit is in HALT
//   retire                     : pulse on the last cycle of each instruction
//   instret                    : retired-instruction count (wraps)
module control_fsm
    import control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchInv,
    output logic [1:0]       PCSource,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             LoadAOut,
    output logic             LoadRegA,
    output logic             LoadRegB,
    output logic             LoadMDR,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             IMemRead,
    output logic             IRWrite,
    output logic             DMemRead,
    output logic             DMemWrite,
    output logic             halted,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q;

    assign instret = instret_q;

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchInv   = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REGB;
        ALUOp       = ALUOP_ADD;
        LoadAOut    = 1'b0;
        LoadRegA    = 1'b0;
        LoadRegB    = 1'b0;
        LoadMDR     = 1'b0;
        RegWrite    = 1'b0;
        MemToReg    = 1'b0;
        IMemRead    = 1'b0;
        IRWrite     = 1'b0;
        DMemRead    = 1'b0;
        DMemWrite   = 1'b0;
        halted      = 1'b0;
        retire      = 1'b0;

        unique case (state_q)
            FETCH: begin
                IMemRead = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                if (imem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // ALUOut <= PC + imm: branch target ready before BRANCH
                LoadRegA = 1'b1;
                LoadRegB = 1'b1;
                LoadAOut = 1'b1;
                ALUSrcB  = SRCB_IMM;
                unique case (opcode)
                    OP_LD, OP_SD: state_d = MEM_ADDR;
                    OP_R:         state_d = EXEC_R;
                    OP_I:         state_d = EXEC_I;
                    OP_BR:        state_d = BRANCH;
                    default:      state_d = HALT;
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
                LoadAOut = 1'b1;
                state_d  = (opcode == OP_LD) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                DMemRead = 1'b1;
                LoadMDR  = dmem_ready;
                if (dmem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            MEM_WRITE: begin
                DMemWrite = 1'b1;
                if (dmem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC_R: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_REGB;
                ALUOp    = ALUOP_RTYPE;
                LoadAOut = 1'b1;
                state_d  = ALU_WB;
            end
            EXEC_I: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_IMM;
                ALUOp    = ALUOP_ITYPE;
                LoadAOut = 1'b1;
                state_d  = ALU_WB;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = SRCB_REGB;
                ALUOp    = ALUOP_SUB;
                PCSource = PCSRC_AOUT;
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    PCWriteCond = 1'b1;
                    BranchInv   = funct3[0];
                    retire      = 1'b1;
                    state_d     = FETCH;
                end else begin
                    state_d = HALT;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_d = HALT;
        endcase

        // Reset suppresses every side effect so an interrupted instruction
        // leaves no trace; selects park at their FETCH values.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            LoadAOut    = 1'b0;
            LoadRegA    = 1'b0;
            LoadRegB    = 1'b0;
            LoadMDR     = 1'b0;
            RegWrite    = 1'b0;
            IMemRead    = 1'b0;
            IRWrite     = 1'b0;
            DMemRead    = 1'b0;
            DMemWrite   = 1'b0;
            retire      = 1'b0;
            halted      = 1'b0;
            MemToReg    = 1'b0;
            BranchInv   = 1'b0;
            PCSource    = PCSRC_ALU;
            ALUSrcA     = 1'b0;
            ALUSrcB     = SRCB_FOUR;
            ALUOp       = ALUOP_ADD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;
    import control_pkg::*;

    localparam int CNT_W = 4;   // small so counter wrap is exercised

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic imem_ready = 1'b0, dmem_ready = 1'b0;
    logic PCWrite, PCWriteCond, BranchInv, ALUSrcA, LoadAOut, LoadRegA, LoadRegB;
    logic LoadMDR, RegWrite, MemToReg, IMemRead, IRWrite, DMemRead, DMemWrite;
    logic halted, retire;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [CNT_W-1:0] instret;

    control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchInv(BranchInv),
        .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .LoadAOut(LoadAOut), .LoadRegA(LoadRegA), .LoadRegB(LoadRegB),
        .LoadMDR(LoadMDR), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .IMemRead(IMemRead), .IRWrite(IRWrite), .DMemRead(DMemRead),
        .DMemWrite(DMemWrite), .halted(halted), .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0: retires, 1: halts
        int cyc;    // cycles up to and including retire / first halted cycle
        int irw, pcw, rw, mtr, dr, dw, mdr, pcwc;
        int binv, psrc, instret;
    } exp_t;

    exp_t q[$];
    int n_checks = 0, n_fail = 0;
    int model_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int a_cyc = 0, a_irw = 0, a_pcw = 0, a_rw = 0, a_mtr = 0, a_dr = 0;
    int a_dw = 0, a_mdr = 0, a_pcwc = 0;
    bit in_halt = 0;
    exp_t e;

    function automatic int strobes();
        return int'({PCWrite, PCWriteCond, LoadAOut, LoadRegA, LoadRegB, LoadMDR,
                     RegWrite, IRWrite, IMemRead, DMemRead, DMemWrite, retire});
    endfunction

    task automatic clear_acc();
        a_cyc = 0; a_irw = 0; a_pcw = 0; a_rw = 0; a_mtr = 0;
        a_dr = 0; a_dw = 0; a_mdr = 0; a_pcwc = 0;
    endtask

    task automatic cmp_counts(input exp_t x);
        chk("cycles", a_cyc, x.cyc);
        chk("IRWrite_cnt", a_irw, x.irw);
        chk("PCWrite_cnt", a_pcw, x.pcw);
        chk("RegWrite_cnt", a_rw, x.rw);
        chk("MemToReg_cnt", a_mtr, x.mtr);
        chk("DMemRead_cnt", a_dr, x.dr);
        chk("DMemWrite_cnt", a_dw, x.dw);
        chk("LoadMDR_cnt", a_mdr, x.mdr);
        chk("PCWriteCond_cnt", a_pcwc, x.pcwc);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_quiet", strobes(), 0);
            clear_acc();
            in_halt = 0;
        end else begin
            a_cyc++;
            a_irw  += int'(IRWrite);
            a_pcw  += int'(PCWrite);
            a_rw   += int'(RegWrite);
            a_mtr  += int'(RegWrite && MemToReg);
            a_dr   += int'(DMemRead);
            a_dw   += int'(DMemWrite);
            a_mdr  += int'(LoadMDR);
            a_pcwc += int'(PCWriteCond);
            if (retire) begin
                if (q.size() == 0) chk("unexpected_retire", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("kind", 0, e.kind);
                    cmp_counts(e);
                    chk("BranchInv", int'(BranchInv), e.binv);
                    chk("PCSource", int'(PCSource), e.psrc);
                    chk("instret", int'(instret), e.instret);
                end
                clear_acc();
            end
            if (halted && !in_halt) begin
                in_halt = 1;
                if (q.size() == 0) chk("unexpected_halt", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("kind", 1, e.kind);
                    cmp_counts(e);
                end
            end
            if (in_halt) begin
                chk("halt_quiet", strobes(), 0);
                chk("halted_held", int'(halted), 1);
            end
        end
    end

    // ---------------- driver + reference model ----------------
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_cnt = 0;
    endtask

    // One instruction: iw FETCH wait cycles, dw data-memory wait cycles.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input int iw, input int dw);
        exp_t x;
        int len, m;
        bit is_ld, is_sd, is_alu, is_br, br_ok;
        is_ld  = (op == OP_LD);
        is_sd  = (op == OP_SD);
        is_alu = (op == OP_R) || (op == OP_I);
        is_br  = (op == OP_BR);
        br_ok  = is_br && (f3 == 3'd0 || f3 == 3'd1);
        m = iw + 3;   // first data-memory cycle after fetch, decode, address
        x = '{kind: 0, cyc: 0, irw: 1, pcw: 1, rw: 0, mtr: 0, dr: 0, dw: 0,
              mdr: 0, pcwc: 0, binv: 0, psrc: 0, instret: 0};
        if (is_alu) begin
            x.cyc = iw + 4; x.rw = 1;
        end else if (is_ld) begin
            x.cyc = iw + dw + 5; x.rw = 1; x.mtr = 1; x.dr = dw + 1; x.mdr = 1;
        end else if (is_sd) begin
            x.cyc = iw + dw + 4; x.dw = dw + 1;
        end else if (br_ok) begin
            x.cyc = iw + 3; x.pcwc = 1; x.binv = int'(f3 == 3'd1); x.psrc = 1;
        end else begin
            x.kind = 1;
            x.cyc  = is_br ? iw + 4 : iw + 3;
        end
        if (x.kind == 0) begin
            x.instret = model_cnt % (1 << CNT_W);
            model_cnt++;
        end
        q.push_back(x);
        len = (x.kind == 1) ? x.cyc + 10 : x.cyc;
        for (int c = 0; c < len; c++) begin
            opcode = op;
            funct3 = f3;
            imem_ready = (c <= iw) ? (c == iw) : 1'($urandom);
            dmem_ready = ((is_ld || is_sd) && c >= m && c <= m + dw) ? (c == m + dw)
                                                                    : 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    // LD abandoned by reset on its first data-memory cycle.
    task automatic issue_abort(input int iw);
        for (int c = 0; c < iw + 3; c++) begin
            opcode = OP_LD;
            funct3 = 3'd3;
            imem_ready = (c <= iw) ? (c == iw) : 1'b1;
            dmem_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        do_reset();
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        logic [6:0] op;
        logic [2:0] f3;
        #1;
        do_reset();
        chk("reset_instret", int'(instret), 0);
        chk("reset_halted", int'(halted), 0);

        issue(OP_R,  3'd0, 0, 0);   // zero-wait add
        issue(OP_LD, 3'd3, 0, 3);   // LD, 3 data wait states
        issue(OP_BR, 3'd1, 0, 0);   // BNE
        issue(OP_BR, 3'd0, 0, 0);   // BEQ
        issue(OP_SD, 3'd3, 2, 0);   // SD, 2 fetch wait states
        issue(OP_I,  3'd5, 1, 0);

        issue(7'b1111111, 3'd0, 0, 0);   // illegal opcode
        do_reset();
        chk("post_halt_instret", int'(instret), 0);
        issue(OP_BR, 3'd4, 1, 0);        // illegal branch funct3
        do_reset();
        chk("post_halt2_instret", int'(instret), 0);

        issue_abort(1);
        chk("abort_instret", int'(instret), 0);
        chk("abort_queue", q.size(), 0);
        issue(OP_R, 3'd0, 0, 0);         // unit resumes from FETCH

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 5);
            f3  = 3'($urandom);
            case (sel)
                0: op = OP_R;
                1: op = OP_I;
                2: op = OP_LD;
                3: op = OP_SD;
                4: begin op = OP_BR; f3 = 3'd0; end
                default: begin op = OP_BR; f3 = 3'd1; end
            endcase
            issue(op, f3, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        chk("final_queue", q.size(), 0);
        chk("final_instret", int'(instret), model_cnt % (1 << CNT_W));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
